// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - parallel-in/serial-out serialiser with one-word hold buffer and frame markers
// Optional even-parity bit appended to each frame when PISO_STREAM_PARITY_EN is defined.
module piso_stream #(
  parameter int   LEN        = 8,
  parameter int   MSB_FIRST  = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] in_data,
  output logic           serial_out,
  output logic           serial_valid,
  output logic           frame_start,
  output logic           frame_end,
  output logic           busy
);

`ifdef PISO_STREAM_PARITY_EN
  localparam int FRAME_BITS = LEN + 1;
`else
  localparam int FRAME_BITS = LEN;
`endif
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS);
  localparam logic [CW-1:0] PENULT_CNT = CW'(FRAME_BITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state, state_nx;
  logic [LEN-1:0]        hold_data;
  logic                  hold_full;
  logic [FRAME_BITS-1:0] shift_reg, shift_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic                  out_nx, valid_nx, start_nx, end_nx;
  logic                  hold_pop, accept;
  logic [FRAME_BITS-1:0] frame;

  // Frame laid out in emission order: frame[0] leaves first.
  always_comb begin
    frame = '0;
    for (int i = 0; i < LEN; i++) begin
      frame[i] = (MSB_FIRST != 0) ? hold_data[LEN-1-i] : hold_data[i];
    end
`ifdef PISO_STREAM_PARITY_EN
    frame[LEN] = ^hold_data;
`endif
  end

  always_comb begin
    state_nx = state;
    shift_nx = shift_reg;
    cnt_nx   = cnt;
    out_nx   = IDLE_LEVEL;
    valid_nx = 1'b0;
    start_nx = 1'b0;
    end_nx   = 1'b0;
    hold_pop = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) hold_pop = 1'b1;
      end
      SHIFT: begin
        if (cnt == LAST_CNT) begin
          if (hold_full) begin
            hold_pop = 1'b1;
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end else begin
          out_nx   = shift_reg[0];
          shift_nx = shift_reg >> 1;
          cnt_nx   = cnt + CW'(1);
          valid_nx = 1'b1;
          end_nx   = (cnt == PENULT_CNT);
        end
      end
      default: state_nx = IDLE;
    endcase
    // A load from hold overrides whatever the shifter would otherwise do.
    if (hold_pop) begin
      state_nx = SHIFT;
      out_nx   = frame[0];
      shift_nx = frame >> 1;
      cnt_nx   = CW'(1);
      valid_nx = 1'b1;
      start_nx = 1'b1;
      end_nx   = 1'b0;
    end
  end

  assign in_ready = !hold_full || hold_pop;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == SHIFT) || hold_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold_data    <= '0;
      hold_full    <= 1'b0;
      shift_reg    <= '0;
      cnt          <= '0;
      serial_out   <= IDLE_LEVEL;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
    end else begin
      state        <= state_nx;
      shift_reg    <= shift_nx;
      cnt          <= cnt_nx;
      serial_out   <= out_nx;
      serial_valid <= valid_nx;
      frame_start  <= start_nx;
      frame_end    <= end_nx;
      if (accept) begin
        hold_data <= in_data;
        hold_full <= 1'b1;
      end else if (hold_pop) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// tb/tb_piso_stream.sv - self-checking bench for piso_stream (both bit orders, streaming, reset abort)
// Parity expectations apply when PISO_STREAM_PARITY_EN is defined.
module tb_piso_stream;

`ifdef PISO_STREAM_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  typedef struct {
    logic [7:0] data;
    logic       msb;
    logic [8:0] exp;   // exp[i] = i-th emitted bit; exp[8] is the parity bit
  } vec_t;

  logic       clk, rst_n;
  logic       v0, v1;
  logic [7:0] d0, d1;
  logic       rdy0, so0, sv0, fs0, fe0, bz0;
  logic       rdy1, so1, sv1, fs1, fe1, bz1;
  logic       sel;
  logic       rdy, so, sv, fs, fe, bz;

  int checks = 0;
  int errors = 0;

  piso_stream #(.LEN(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .serial_out(so0), .serial_valid(sv0), .frame_start(fs0), .frame_end(fe0), .busy(bz0)
  );

  piso_stream #(.LEN(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .serial_out(so1), .serial_valid(sv1), .frame_start(fs1), .frame_end(fe1), .busy(bz1)
  );

  assign rdy = sel ? rdy1 : rdy0;
  assign so  = sel ? so1  : so0;
  assign sv  = sel ? sv1  : sv0;
  assign fs  = sel ? fs1  : fs0;
  assign fe  = sel ? fe1  : fe0;
  assign bz  = sel ? bz1  : bz0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    sel = v.msb;
    @(negedge clk);
    chk($sformatf("ready_idle_%h", v.data), rdy, 1);
    if (v.msb) begin v1 = 1'b1; d1 = v.data; end
    else       begin v0 = 1'b1; d0 = v.data; end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    chk($sformatf("preload_valid_%h", v.data), sv, 0);
    chk($sformatf("preload_busy_%h", v.data), bz, 1);
    for (int k = 0; k < FB; k++) begin
      @(negedge clk);
      chk($sformatf("valid_%h_b%0d", v.data, k), sv, 1);
      chk($sformatf("bit_%h_b%0d", v.data, k), so, v.exp[k]);
      chk($sformatf("start_%h_b%0d", v.data, k), fs, (k == 0));
      chk($sformatf("end_%h_b%0d", v.data, k), fe, (k == FB - 1));
    end
    @(negedge clk);
    chk($sformatf("post_valid_%h", v.data), sv, 0);
    chk($sformatf("post_out_%h", v.data), so, 0);
    chk($sformatf("post_end_%h", v.data), fe, 0);
    chk($sformatf("post_busy_%h", v.data), bz, 0);
  endtask

  vec_t       vecs[6];
  logic [7:0] words[3];
  logic [8:0] sexp[3];
  logic       got[40];
  int         starts[$];
  int         idx, nbits, gap, notready, took_cnt;
  logic       started, took;
  logic [8:0] rx;

  initial begin
    vecs[0] = '{data: 8'hA5, msb: 1'b0, exp: 9'h0A5};
    vecs[1] = '{data: 8'h81, msb: 1'b1, exp: 9'h081};
    vecs[2] = '{data: 8'h07, msb: 1'b0, exp: 9'h107};
    vecs[3] = '{data: 8'h03, msb: 1'b0, exp: 9'h003};
    vecs[4] = '{data: 8'h01, msb: 1'b1, exp: 9'h180};
    vecs[5] = '{data: 8'h3C, msb: 1'b0, exp: 9'h03C};
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    sexp[0] = 9'h101; sexp[1] = 9'h102; sexp[2] = 9'h003;

    clk = 1'b0; rst_n = 1'b0; sel = 1'b0;
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h55; d1 = 8'hAA;

    // Reset held for two edges with in_valid asserted
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      chk("rst_valid0", sv0, 0);
      chk("rst_out0", so0, 0);
      chk("rst_busy0", bz0, 0);
      chk("rst_valid1", sv1, 0);
      chk("rst_busy1", bz1, 0);
    end
    rst_n = 1'b1; v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    chk("rel_ready0", rdy0, 1);
    chk("rel_ready1", rdy1, 1);
    chk("rel_busy0", bz0, 0);
    chk("rel_busy1", bz1, 0);
    chk("rel_start0", fs0, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Streaming three words with in_valid held high
    sel = 1'b0; idx = 0; nbits = 0; gap = 0; notready = 0; started = 1'b0;
    for (int c = 0; c < 3 * FB + 20; c++) begin
      @(negedge clk);
      if (sv0) begin
        if (fs0) starts.push_back(nbits);
        if (nbits < 40) got[nbits] = so0;
        nbits++;
        started = 1'b1;
      end else if (started && nbits < 3 * FB) begin
        gap++;
      end
      if (idx < 3) begin
        v0 = 1'b1; d0 = words[idx];
        if (!rdy0) notready++;
        took = rdy0;
      end else begin
        v0 = 1'b0; took = 1'b0;
      end
      @(posedge clk);
      if (took) idx++;
    end
    v0 = 1'b0;
    chk("stream_words_taken", idx, 3);
    chk("stream_bit_count", nbits, 3 * FB);
    chk("stream_gap", gap, 0);
    chk("stream_notready_seen", (notready > 0), 1);
    chk("stream_start_count", starts.size(), 3);
    for (int w = 0; w < 3; w++) begin
      rx = '0;
      for (int b = 0; b < FB; b++) rx[b] = got[w * FB + b];
      chk($sformatf("stream_word%0d", w), rx, sexp[w] & ((9'h1 << FB) - 9'h1));
      if (w < starts.size()) chk($sformatf("stream_start%0d", w), starts[w], w * FB);
    end
    @(negedge clk);
    chk("stream_idle_after", sv0, 0);

    // Reset mid-frame with a second word held
    @(negedge clk);
    v0 = 1'b1; d0 = 8'hFF;
    @(negedge clk);
    d0 = 8'h0F;
    chk("abort_ready_pop", rdy0, 1);
    @(negedge clk);
    v0 = 1'b0;
    chk("abort_bit1", sv0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("abort_bit3_out", so0, 1);
    chk("abort_hold_busy", bz0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", sv0, 0);
    chk("abort_out", so0, 0);
    chk("abort_start", fs0, 0);
    chk("abort_end", fe0, 0);
    chk("abort_busy", bz0, 0);
    rst_n = 1'b1;
    took_cnt = 0;
    for (int c = 0; c < 2 * FB + 4; c++) begin
      @(negedge clk);
      if (sv0 || bz0) took_cnt++;
    end
    chk("abort_no_resume", took_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
